// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch sequencer: FSM state codes and default widths.
package pc_fetch_unit_pkg;

   localparam int unsigned DEFAULT_ADDR_W = 10;
   localparam int unsigned INSTR_W        = 16;
   localparam int unsigned BRANCH_W       = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_ISSUE = 3'd2;
   localparam logic [2:0] ST_EXEC  = 3'd3;
   localparam logic [2:0] ST_HALT  = 3'd4;

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// Combinational next-PC select: wrapping increment or truncated branch target.
module pc_next_calc
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic [ADDR_W-1:0]   pc,
   input  logic                take_branch,
   input  logic [BRANCH_W-1:0] branch_target,
   output logic [ADDR_W-1:0]   pc_next
);

   always_comb begin
      if (take_branch) begin
         pc_next = branch_target[ADDR_W-1:0];
      end else begin
         pc_next = pc + ADDR_W'(1);
      end
   end

   // Target bits above the address width are dropped by design.
   if (ADDR_W < BRANCH_W) begin : g_unused_hi
      logic unused_target_hi;
      assign unused_target_hi = ^branch_target[BRANCH_W-1:ADDR_W];
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Non-pipelined PC and instruction-fetch sequencer: fetch, issue to decode, wait for execute,
// then advance or branch the PC. One instruction in flight.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter int unsigned        ADDR_W   = DEFAULT_ADDR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int unsigned        CNT_W    = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   output logic                 imem_req,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_data,
   output logic [INSTR_W-1:0]   instr,
   output logic                 instr_valid,
   input  logic                 exec_done,
   input  logic                 is_branch,
   input  logic                 compres,
   input  logic [BRANCH_W-1:0]  branch_target,
   input  logic                 halt,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted,
   output logic [CNT_W-1:0]     instr_count
);

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_next;
   logic [INSTR_W-1:0] instr_q;
   logic               instr_valid_q;
   logic               halted_q;
   logic [CNT_W-1:0]   count_q;
   logic               fetch_ack;
   logic               retire;

   assign fetch_ack = (state_q == ST_FETCH) && imem_ack;
   assign retire    = (state_q == ST_EXEC) && exec_done;

   pc_next_calc #(
      .ADDR_W (ADDR_W)
   ) u_pc_next_calc (
      .pc            (pc_q),
      .take_branch   (is_branch && compres),
      .branch_target (branch_target),
      .pc_next       (pc_next)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: if (imem_ack) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_EXEC;
         ST_EXEC:  if (exec_done) state_d = halt ? ST_HALT : ST_FETCH;
         ST_HALT:  state_d = ST_HALT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         instr_valid_q <= fetch_ack;
         if (fetch_ack) begin
            instr_q <= imem_data;
         end
         if (retire) begin
            if (!(&count_q)) begin
               count_q <= count_q + CNT_W'(1);
            end
            // Halt wins over any branch outcome and freezes the PC.
            if (halt) begin
               halted_q <= 1'b1;
            end else begin
               pc_q <= pc_next;
            end
         end
      end
   end

   // Request is decoded from state so an asynchronous reset drops it immediately.
   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign halted      = halted_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a phase-level reference model checked every cycle.
module tb_pc_fetch_unit;

   localparam int P_IDLE  = 0;
   localparam int P_FETCH = 1;
   localparam int P_ISSUE = 2;
   localparam int P_EXEC  = 3;
   localparam int P_HALT  = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic        imem_req;
   logic [9:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic        exec_done;
   logic        is_branch;
   logic        compres;
   logic [15:0] branch_target;
   logic        halt;
   logic [9:0]  pc;
   logic        halted;
   logic [15:0] instr_count;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   int          m_phase;
   int          m_pc;
   logic [15:0] m_instr;
   bit          m_valid;
   bit          m_halted;
   int          m_count;

   pc_fetch_unit #(
      .ADDR_W   (10),
      .RESET_PC (10'd0),
      .CNT_W    (16)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .exec_done     (exec_done),
      .is_branch     (is_branch),
      .compres       (compres),
      .branch_target (branch_target),
      .halt          (halt),
      .pc            (pc),
      .halted        (halted),
      .instr_count   (instr_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: one instruction walks fetch -> issue -> execute.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_phase  = P_IDLE;
         m_pc     = 0;
         m_instr  = '0;
         m_valid  = 1'b0;
         m_halted = 1'b0;
         m_count  = 0;
      end else begin
         m_valid = 1'b0;
         case (m_phase)
            P_IDLE: if (start) m_phase = P_FETCH;
            P_FETCH: if (imem_ack) begin
               m_instr = imem_data;
               m_valid = 1'b1;
               m_phase = P_ISSUE;
            end
            P_ISSUE: m_phase = P_EXEC;
            P_EXEC: if (exec_done) begin
               if (m_count < 65535) m_count = m_count + 1;
               if (halt) begin
                  m_halted = 1'b1;
                  m_phase  = P_HALT;
               end else begin
                  if (is_branch && compres) m_pc = int'(branch_target) % 1024;
                  else m_pc = (m_pc + 1) % 1024;
                  m_phase = P_FETCH;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         check("imem_req", imem_req, (m_phase == P_FETCH));
         if (m_phase == P_FETCH) check("imem_addr", imem_addr, m_pc);
         check("instr_valid", instr_valid, m_valid);
         check("instr", instr, m_instr);
         check("pc", pc, m_pc);
         check("halted", halted, m_halted);
         check("instr_count", instr_count, m_count);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20; i++) begin
         if (imem_req) break;
         tick();
      end
      check("req_seen", imem_req, 1);
   endtask

   task automatic fetch(input int exp_addr, input int delay, input logic [15:0] data);
      wait_req();
      check("fetch_addr", imem_addr, exp_addr);
      for (int i = 0; i < delay; i++) begin
         check("req_held", imem_req, 1);
         check("addr_stable", imem_addr, exp_addr);
         tick();
      end
      imem_ack  = 1'b1;
      imem_data = data;
      tick();
      imem_ack  = 1'b0;
      imem_data = 16'hdead;
      check("issue_valid", instr_valid, 1);
      check("issue_instr", instr, data);
   endtask

   task automatic exec(input int waits, input bit br, input bit cmp, input logic [15:0] tgt,
                       input bit hl);
      tick();
      for (int i = 0; i < waits; i++) begin
         // Branch inputs are noise while exec_done is low.
         is_branch = 1'b1;
         compres   = 1'b1;
         tick();
      end
      exec_done     = 1'b1;
      is_branch     = br;
      compres       = cmp;
      branch_target = tgt;
      halt          = hl;
      tick();
      exec_done = 1'b0;
      is_branch = 1'b0;
      compres   = 1'b0;
      halt      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0;
      exec_done = 1'b0; is_branch = 1'b0; compres = 1'b0; branch_target = '0; halt = 1'b0;
      #1;
      chk_en = 1'b1;
      check("rst_req", imem_req, 0);
      check("rst_pc", pc, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_count", instr_count, 0);
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check("idle_req", imem_req, 0);
      start = 1'b1; tick(); start = 1'b0;

      // Sequential fetch, no branches.
      fetch(0, 0, 16'h1000); exec(0, 0, 0, 16'h0, 0);
      fetch(1, 0, 16'h1001); exec(0, 0, 0, 16'h0, 0);
      fetch(2, 0, 16'h1002); exec(0, 0, 0, 16'h0, 0);
      check("count_after_3", instr_count, 3);

      // Branch taken / not taken.
      fetch(3, 0, 16'h2003);  exec(1, 1, 1, 16'h0005, 0);
      fetch(5, 0, 16'h2005);  exec(0, 1, 1, 16'h0040, 0);
      fetch(10'h040, 0, 16'h2040); exec(2, 1, 1, 16'h0005, 0);
      fetch(5, 0, 16'h2105);  exec(0, 1, 0, 16'h0040, 0);
      fetch(6, 0, 16'h2006);  exec(0, 1, 1, 16'h03ff, 0);

      // Wrap and target truncation.
      fetch(10'h3ff, 0, 16'h33ff); exec(0, 0, 0, 16'h0, 0);
      fetch(0, 0, 16'h3000);       exec(0, 1, 1, 16'hfc12, 0);

      // Slow memory: four wait states.
      fetch(10'h012, 4, 16'h4012); exec(0, 0, 0, 16'h0, 0);

      // Halt beats a taken branch.
      fetch(10'h013, 0, 16'h5013); exec(0, 1, 1, 16'h0100, 1);
      check("halted", halted, 1);
      check("halt_pc", pc, 10'h013);
      check("halt_count", instr_count, 12);
      for (int i = 0; i < 8; i++) begin
         start = i[0]; imem_ack = 1'b1; exec_done = 1'b1;
         tick();
         check("halt_no_req", imem_req, 0);
      end
      start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;

      // Reset mid-fetch.
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      check("post_rst_halted", halted, 0);
      start = 1'b1; tick(); start = 1'b0;
      wait_req();
      tick();
      reset_n = 1'b0;
      #1;
      check("rst_drop_req", imem_req, 0);
      check("rst_drop_valid", instr_valid, 0);
      check("rst_drop_pc", pc, 0);
      imem_ack = 1'b1; imem_data = 16'hbeef;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check("late_ack_req", imem_req, 0);
      check("late_ack_instr", instr, 0);
      imem_ack = 1'b0;
      tick();
      check("needs_start", imem_req, 0);
      start = 1'b1; tick(); start = 1'b0;
      fetch(0, 0, 16'h7777); exec(0, 0, 0, 16'h0, 0);
      fetch(1, 0, 16'h7778);
      check("final_count", instr_count, 1);
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
